// File: rtl/approx_mult_32x32.sv
// Unsigned 32x32->64 multiplier built recursively from Kulkarni 2x2 blocks with run-time exact/approx select.
// Optional APPROX_HIT_EN macro adds the registered approx_hit flag output.

module km_leaf_2x2 (
   input  logic [1:0] x_i,
   input  logic [1:0] w_i,
   input  logic       precise_en_i,
   output logic [3:0] p_o
);
   logic [3:0] exact_p;
   logic [3:0] approx_p;

   assign exact_p  = 4'(x_i) * 4'(w_i);
   // Kulkarni cell: 3*3 collapses to 3'b111, every other pair is exact
   assign approx_p = {1'b0,
                      x_i[1] & w_i[1],
                      (x_i[1] & w_i[0]) | (x_i[0] & w_i[1]),
                      x_i[0] & w_i[0]};
   assign p_o      = precise_en_i ? exact_p : approx_p;
endmodule

module km_mul4 (
   input  logic [3:0] x_i,
   input  logic [3:0] w_i,
   input  logic       precise_en_i,
   output logic [7:0] p_o
);
   logic [3:0] sub_p [4];

   // Sub-product order: 0 = lo*lo, 1 = hi*lo, 2 = lo*hi, 3 = hi*hi
   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      km_leaf_2x2 u_leaf (
         .x_i          ((gi % 2 == 1) ? x_i[3:2] : x_i[1:0]),
         .w_i          ((gi / 2 == 1) ? w_i[3:2] : w_i[1:0]),
         .precise_en_i (precise_en_i),
         .p_o          (sub_p[gi])
      );
   end

   assign p_o = 8'(sub_p[0])
              + (8'(sub_p[1]) << 2)
              + (8'(sub_p[2]) << 2)
              + (8'(sub_p[3]) << 4);
endmodule

module km_mul8 (
   input  logic [7:0]  x_i,
   input  logic [7:0]  w_i,
   input  logic        precise_en_i,
   output logic [15:0] p_o
);
   logic [7:0] sub_p [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      km_mul4 u_mul (
         .x_i          ((gi % 2 == 1) ? x_i[7:4] : x_i[3:0]),
         .w_i          ((gi / 2 == 1) ? w_i[7:4] : w_i[3:0]),
         .precise_en_i (precise_en_i),
         .p_o          (sub_p[gi])
      );
   end

   assign p_o = 16'(sub_p[0])
              + (16'(sub_p[1]) << 4)
              + (16'(sub_p[2]) << 4)
              + (16'(sub_p[3]) << 8);
endmodule

module km_mul16 (
   input  logic [15:0] x_i,
   input  logic [15:0] w_i,
   input  logic        precise_en_i,
   output logic [31:0] p_o
);
   logic [15:0] sub_p [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      km_mul8 u_mul (
         .x_i          ((gi % 2 == 1) ? x_i[15:8] : x_i[7:0]),
         .w_i          ((gi / 2 == 1) ? w_i[15:8] : w_i[7:0]),
         .precise_en_i (precise_en_i),
         .p_o          (sub_p[gi])
      );
   end

   assign p_o = 32'(sub_p[0])
              + (32'(sub_p[1]) << 8)
              + (32'(sub_p[2]) << 8)
              + (32'(sub_p[3]) << 16);
endmodule

module km_mul32 (
   input  logic [31:0] x_i,
   input  logic [31:0] w_i,
   input  logic        precise_en_i,
   output logic [63:0] p_o
);
   logic [31:0] sub_p [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      km_mul16 u_mul (
         .x_i          ((gi % 2 == 1) ? x_i[31:16] : x_i[15:0]),
         .w_i          ((gi / 2 == 1) ? w_i[31:16] : w_i[15:0]),
         .precise_en_i (precise_en_i),
         .p_o          (sub_p[gi])
      );
   end

   // Approx result never exceeds the exact one, so 2N bits always hold the sum
   assign p_o = 64'(sub_p[0])
              + (64'(sub_p[1]) << 16)
              + (64'(sub_p[2]) << 16)
              + (64'(sub_p[3]) << 32);
endmodule

module approx_mult_32x32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        precise_en,
`ifdef APPROX_HIT_EN
   output logic        approx_hit,
`endif
   output logic [63:0] y
);
   logic [63:0] y_d;
   logic [63:0] y_q;

   km_mul32 u_mul32 (
      .x_i          (a),
      .w_i          (b),
      .precise_en_i (precise_en),
      .p_o          (y_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= 64'h0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y = y_q;

`ifdef APPROX_HIT_EN
   logic [15:0] a_is3;
   logic [15:0] b_is3;
   logic        hit_d;
   logic        hit_q;

   for (genvar gi = 0; gi < 16; gi++) begin : g_digit
      assign a_is3[gi] = &a[2*gi +: 2];
      assign b_is3[gi] = &b[2*gi +: 2];
   end

   // Some a-digit and some b-digit both equal 3 means some leaf sees 3*3
   assign hit_d = ~precise_en & (|a_is3) & (|b_is3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q <= 1'b0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign approx_hit = hit_q;
`endif
endmodule

// File: tb/tb_approx_mult_32x32.sv
// Scoreboard bench for approx_mult_32x32: expected products come from a*b minus the digit-pair error formula.
`timescale 1ns/1ps

module tb_approx_mult_32x32;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        precise_en;
   logic [63:0] y;
`ifdef APPROX_HIT_EN
   logic        approx_hit;
`endif

   always #5 clk = ~clk;

   approx_mult_32x32 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .precise_en (precise_en),
`ifdef APPROX_HIT_EN
      .approx_hit (approx_hit),
`endif
      .y          (y)
   );

   typedef struct {
      logic [63:0] exp_y;
      logic [63:0] exact;
      logic        pe;
      logic        hit;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;
   logic issue = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_y(input logic [31:0] ma, input logic [31:0] mb, input logic mpe);
      logic [63:0] p;
      p = 64'(ma) * 64'(mb);
      if (!mpe) begin
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
               if (ma[2*i +: 2] == 2'd3 && mb[2*j +: 2] == 2'd3)
                  p = p - (64'd2 << (2 * (i + j)));
      end
      return p;
   endfunction

   function automatic logic model_hit(input logic [31:0] ma, input logic [31:0] mb, input logic mpe);
      logic ha = 1'b0;
      logic hb = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (ma[2*i +: 2] == 2'd3) ha = 1'b1;
         if (mb[2*i +: 2] == 2'd3) hb = 1'b1;
      end
      return !mpe && ha && hb;
   endfunction

   task automatic issue_exp(input logic [31:0] ta, input logic [31:0] tb, input logic tpe, input logic [63:0] texp);
      sb_t e;
      @(negedge clk);
      a = ta; b = tb; precise_en = tpe; issue = 1'b1;
      e.exp_y = texp;
      e.exact = 64'(ta) * 64'(tb);
      e.pe    = tpe;
      e.hit   = model_hit(ta, tb, tpe);
      sb.push_back(e);
   endtask

   task automatic issue_op(input logic [31:0] ta, input logic [31:0] tb, input logic tpe);
      issue_exp(ta, tb, tpe, model_y(ta, tb, tpe));
   endtask

   task automatic idle();
      @(negedge clk);
      issue = 1'b0;
   endtask

   // Each issued operation must show up on y right after the edge that sampled it
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && issue) begin
            sb_t e;
            #1;
            if (sb.size() == 0) begin
               check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check(e.pe ? "exact_y" : "approx_y", y, e.exp_y);
               if (!e.pe) check("approx_le_exact", 64'(y <= e.exact), 64'd1);
`ifdef APPROX_HIT_EN
               check("approx_hit", 64'(approx_hit), 64'(e.hit));
`endif
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; precise_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_hold", y, 64'h0);
      rst_n = 1'b1;
      #1 check("reset_release", y, 64'h0);

      issue_exp(32'd3, 32'd3, 1'b1, 64'd9);
      issue_exp(32'd3, 32'd3, 1'b0, 64'd7);
      issue_exp(32'hFF, 32'hFF, 1'b1, 64'd65025);
      issue_exp(32'hFF, 32'hFF, 1'b0, 64'd50575);
      issue_exp(32'hF, 32'hF, 1'b0, 64'd175);
      issue_exp(32'hF, 32'hF, 1'b1, 64'd225);
      issue_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
      issue_op (32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue_exp(32'h0, 32'hFFFF_FFFF, 1'b0, 64'h0);
      issue_exp(32'hFFFF_FFFF, 32'h0, 1'b1, 64'h0);
      issue_exp(32'h0, 32'h0, 1'b0, 64'h0);
      issue_exp(32'd5, 32'd7, 1'b1, 64'd35);

      // Asynchronous reset with a new operand pair already on the inputs
      @(negedge clk);
      issue = 1'b0; a = 32'd9; b = 32'd9; precise_en = 1'b1;
      #1 rst_n = 1'b0;
      #1 check("async_reset", y, 64'h0);
      @(posedge clk);
      #1 check("reset_discard", y, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("release_no_edge", y, 64'h0);
      issue_op(32'd9, 32'd9, 1'b0);

      for (int m = 1; m >= 0; m--)
         for (int ia = 0; ia < 256; ia++)
            for (int ib = 0; ib < 256; ib += 5)
               issue_op(32'(ia), 32'(ib), m[0]);

      for (int k = 0; k < 2000; k++)
         issue_op($urandom, $urandom, k[0]);
      for (int k = 0; k < 500; k++)
         issue_op($urandom | 32'hCCCC_CCCC, $urandom | 32'h3333_3333, k[0]);

      idle();
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      check("sb_drain", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
